// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle ops from a 5-bit opcode, plus iterative
// shift-add multiply and restoring unsigned divide/remainder (one bit per cycle).
module alu_seq #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ERR_VALUE = 329010
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [4:0]       op_i,
   input  logic [WIDTH-1:0] in_1_i,
   input  logic [WIDTH-1:0] in_2_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_o,
   output logic             err_o,
   output logic             busy_o
);

   localparam int unsigned      SW     = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ErrVal = WIDTH'(ERR_VALUE);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       out_q, out_d;
   logic [WIDTH-1:0]       opa_q, opa_d;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [SW-1:0]          cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   hi_q, hi_d;

   logic [WIDTH-1:0]       alu_res;
   logic                   alu_err;
   logic [SW-1:0]          sh;
   logic [WIDTH:0]         mul_sum, div_trial, div_diff;
   logic [2*WIDTH-1:0]     mul_next, div_next;

   always_comb begin
      sh      = in_2_i[SW-1:0];
      alu_res = '0;
      alu_err = 1'b0;
      case (op_i)
         5'd0:    alu_res = in_1_i + in_2_i;
         5'd1:    alu_res = in_1_i - in_2_i;
         5'd2:    alu_res = in_1_i ^ in_2_i;
         5'd3:    alu_res = in_1_i | in_2_i;
         5'd4:    alu_res = in_1_i & in_2_i;
         5'd5:    alu_res = in_1_i << sh;
         5'd6:    alu_res = in_1_i >> sh;
         5'd7:    alu_res = $unsigned($signed(in_1_i) >>> sh);
         5'd8:    alu_res = {{(WIDTH-1){1'b0}}, $signed(in_1_i) < $signed(in_2_i)};
         5'd9:    alu_res = {{(WIDTH-1){1'b0}}, in_1_i < in_2_i};
         5'd10:   alu_res = {{(WIDTH-1){1'b0}}, in_1_i == in_2_i};
         5'd11:   alu_res = {{(WIDTH-1){1'b0}}, in_1_i != in_2_i};
         5'd12:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_1_i) >= $signed(in_2_i)};
         5'd13:   alu_res = {{(WIDTH-1){1'b0}}, in_1_i >= in_2_i};
         5'd14:   alu_res = '0;
         default: begin
            alu_res = ErrVal;
            alu_err = 1'b1;
         end
      endcase
   end

   // acc = {partial high, remaining multiplier} for MUL, {remainder, dividend/quotient} for DIV
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_trial = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_trial - {1'b0, opa_q};
      div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      opa_d   = opa_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      hi_d    = hi_q;
      if (flush_i) begin
         state_d = StIdle;
         out_d   = '0;
         err_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i) begin
                  cnt_d = SW'(WIDTH - 1);
                  hi_d  = op_i[0];
                  if (op_i[4:1] == 4'b1000) begin
                     opa_d   = in_1_i;
                     acc_d   = {{WIDTH{1'b0}}, in_2_i};
                     state_d = StMul;
                  end else if (op_i[4:1] == 4'b1001) begin
                     if (in_2_i == '0) begin
                        // Divide by zero skips iteration: quotient all ones, remainder = dividend
                        out_d   = op_i[0] ? in_1_i : '1;
                        err_d   = 1'b0;
                        state_d = StDone;
                     end else begin
                        opa_d   = in_2_i;
                        acc_d   = {{WIDTH{1'b0}}, in_1_i};
                        state_d = StDiv;
                     end
                  end else begin
                     out_d   = alu_res;
                     err_d   = alu_err;
                     state_d = StDone;
                  end
               end
            end
            StMul: begin
               acc_d = mul_next;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  out_d   = hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                  err_d   = 1'b0;
                  state_d = StDone;
               end
            end
            StDiv: begin
               acc_d = div_next;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  out_d   = hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
                  err_d   = 1'b0;
                  state_d = StDone;
               end
            end
            StDone: begin
               if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         out_q   <= '0;
         opa_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         hi_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         opa_q   <= opa_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         hi_q    <= hi_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign busy_o      = (state_q == StMul) || (state_q == StDiv);
   assign out_o       = out_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of single ops with expected result/latency, then
// hand sequences for output stall, flush and asynchronous reset mid-operation.
module tb_alu_seq;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [4:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready, out_valid, err, busy;
   logic [W-1:0]  res;

   int n_cmp = 0;
   int n_bad = 0;

   alu_seq #(.WIDTH(W), .ERR_VALUE(329010)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .in_1_i      (a),
      .in_2_i      (b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_o       (res),
      .err_o       (err),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] res;
      logic         err;
      int           lat;
      int           nbusy;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [W-1:0] r, input logic e, input int l, input int nb);
      vec_t v;
      v.op = o; v.x = x; v.y = y; v.res = r; v.err = e; v.lat = l; v.nbusy = nb;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] exp_res, input logic exp_err,
                         input int exp_lat, input int exp_nbusy);
      int lat;
      int nb;
      @(negedge clk);
      check({tag, ".in_ready"}, W'(in_ready), 32'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = ~x; b = ~y;
      lat = 1; nb = 0;
      while (!out_valid && lat < 100) begin
         if (busy && !in_ready) nb++;
         @(negedge clk);
         lat++;
      end
      check({tag, ".lat"}, W'(lat), W'(exp_lat));
      check({tag, ".out"}, res, exp_res);
      check({tag, ".err"}, W'(err), W'(exp_err));
      check({tag, ".busy_cycles"}, W'(nb), W'(exp_nbusy));
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int bad;
      int seen;

      vq.push_back(mk(5'd0,  32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, 1, 0));
      vq.push_back(mk(5'd1,  32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 1, 0));
      vq.push_back(mk(5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1, 0));
      vq.push_back(mk(5'd3,  32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1, 0));
      vq.push_back(mk(5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1, 0));
      vq.push_back(mk(5'd5,  32'd1,         32'd33,       32'd2,        1'b0, 1, 0));
      vq.push_back(mk(5'd6,  32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0, 1, 0));
      vq.push_back(mk(5'd7,  32'h8000_0000, 32'd4,        32'hF800_0000, 1'b0, 1, 0));
      vq.push_back(mk(5'd8,  32'hFFFF_FFFF, 32'd1,        32'd1,        1'b0, 1, 0));
      vq.push_back(mk(5'd9,  32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, 1, 0));
      vq.push_back(mk(5'd10, 32'd7,         32'd7,        32'd1,        1'b0, 1, 0));
      vq.push_back(mk(5'd11, 32'd7,         32'd7,        32'd0,        1'b0, 1, 0));
      vq.push_back(mk(5'd12, 32'hFFFF_FFFF, 32'd0,        32'd0,        1'b0, 1, 0));
      vq.push_back(mk(5'd13, 32'hFFFF_FFFF, 32'd0,        32'd1,        1'b0, 1, 0));
      vq.push_back(mk(5'd14, 32'd3,         32'd4,        32'd0,        1'b0, 1, 0));
      vq.push_back(mk(5'd15, 32'd3,         32'd4,        32'd329010,   1'b1, 1, 0));
      vq.push_back(mk(5'd16, 32'h0001_0000, 32'h0001_0000, 32'd0,       1'b0, 33, 32));
      vq.push_back(mk(5'd17, 32'h0001_0000, 32'h0001_0000, 32'd1,       1'b0, 33, 32));
      vq.push_back(mk(5'd16, 32'd7,         32'd6,        32'd42,       1'b0, 33, 32));
      vq.push_back(mk(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 32));
      vq.push_back(mk(5'd18, 32'd100,       32'd7,        32'd14,       1'b0, 33, 32));
      vq.push_back(mk(5'd19, 32'd100,       32'd7,        32'd2,        1'b0, 33, 32));
      vq.push_back(mk(5'd18, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1'b0, 33, 32));
      vq.push_back(mk(5'd18, 32'd5,         32'd0,        32'hFFFF_FFFF, 1'b0, 1, 0));
      vq.push_back(mk(5'd19, 32'd5,         32'd0,        32'd5,        1'b0, 1, 0));
      vq.push_back(mk(5'd31, 32'd1,         32'd1,        32'd329010,   1'b1, 1, 0));

      // Reset values
      #12;
      check("rst.out_valid", W'(out_valid), 32'd0);
      check("rst.in_ready", W'(in_ready), 32'd1);
      check("rst.busy", W'(busy), 32'd0);
      check("rst.out", res, 32'd0);
      check("rst.err", W'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         run_op($sformatf("vec%0d_op%0d", i, vq[i].op), vq[i].op, vq[i].x, vq[i].y,
                vq[i].res, vq[i].err, vq[i].lat, vq[i].nbusy);
      end

      // Output stall: result held, new in_valid ignored
      @(negedge clk);
      out_ready = 1'b0;
      op = 5'd0; a = 32'd2; b = 32'd3; in_valid = 1'b1;
      @(negedge clk);
      check("hold.first_valid", W'(out_valid), 32'd1);
      op = 5'd1; a = 32'd9; b = 32'd1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (res !== 32'd5 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("hold.stable_cycles_bad", W'(bad), 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("hold.release_in_ready", W'(in_ready), 32'd1);
      check("hold.release_out_valid", W'(out_valid), 32'd0);
      repeat (2) @(negedge clk);
      check("hold.not_queued", W'(out_valid | busy), 32'd0);

      // flush at MUL cycle 10
      op = 5'd16; a = 32'd123; b = 32'd456; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("flush.was_busy", W'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush.out_valid", W'(out_valid), 32'd0);
      check("flush.busy", W'(busy), 32'd0);
      check("flush.in_ready", W'(in_ready), 32'd1);
      check("flush.err", W'(err), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush.no_late_result", W'(seen), 32'd0);

      // flush beats in_valid in the same cycle
      op = 5'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush_prio.in_ready", W'(in_ready), 32'd1);
      check("flush_prio.out_valid", W'(out_valid), 32'd0);

      // flush in DONE clears err
      out_ready = 1'b0;
      op = 5'd15; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("flush_done.err_before", W'(err), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b1;
      check("flush_done.err", W'(err), 32'd0);
      check("flush_done.out_valid", W'(out_valid), 32'd0);

      run_op("post_flush_add", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

      // Async reset mid-DIV
      @(negedge clk);
      op = 5'd18; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst.busy", W'(busy), 32'd0);
      check("arst.in_ready", W'(in_ready), 32'd1);
      check("arst.out_valid", W'(out_valid), 32'd0);
      check("arst.out", res, 32'd0);
      check("arst.err", W'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("post_rst_add", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);
      run_op("op22", 5'd22, 32'd2, 32'd3, 32'd329010, 1'b1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
